// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: integrate-and-dump decimator behind a small output FIFO.
// The block sums DECIM consecutive accepted FIR samples. The sum is then
// arithmetically shifted right by SHIFT, saturated to NUM_OUTPUT_BITS, and
// pushed into a FIFO_DEPTH-entry FIFO. The FIFO is drained with a valid/ready
// handshake.
// The overflow and sat flags are sticky. Only rst_n or clr clears them.
// Optional feature: define FIR_DECIM_ROUND_EN to round half up before the shift.
// The default build truncates toward minus infinity.
module fir_decim_fifo #(
    parameter int NUM_INPUT_BITS  = 16,
    parameter int NUM_OUTPUT_BITS = 8,
    parameter int DECIM           = 4,
    parameter int SHIFT           = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic signed [NUM_INPUT_BITS-1:0]  In,
    input  logic                              in_valid,
    input  logic                              clr,
    output logic signed [NUM_OUTPUT_BITS-1:0] Out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              overflow,
    output logic                              sat
);

    localparam int PH_W  = $clog2(DECIM);
    localparam int ACC_W = NUM_INPUT_BITS + PH_W;
    // The rounding bias can carry past the accumulator range, so the
    // post-processing path gets one extra bit.
    localparam int SUM_W = ACC_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIAS  = (2 ** SHIFT) / 2;

    localparam logic [PH_W-1:0]          PH_LAST  = PH_W'(DECIM - 1);
    localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic signed [SUM_W-1:0]  OUT_MAX  = SUM_W'((2 ** (NUM_OUTPUT_BITS - 1)) - 1);
    localparam logic signed [SUM_W-1:0]  OUT_MIN  = ~OUT_MAX;

    logic signed [ACC_W-1:0]           acc_q, acc_d;
    logic [PH_W-1:0]                   phase_q, phase_d;
    logic signed [NUM_OUTPUT_BITS-1:0] mem_q [FIFO_DEPTH];
    logic signed [NUM_OUTPUT_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic                              overflow_q, overflow_d;
    logic                              sat_q, sat_d;

    logic signed [ACC_W-1:0]           in_ext;
    logic signed [ACC_W-1:0]           sum;
    logic signed [SUM_W-1:0]           sum_ext;
    logic signed [SUM_W-1:0]           biased;
    logic signed [SUM_W-1:0]           shifted;
    logic                              clip_hi;
    logic                              clip_lo;
    logic signed [NUM_OUTPUT_BITS-1:0] result;

    logic                              last_phase;
    logic                              push;
    logic                              pop;
    logic                              full;
    logic                              do_push;

    // Sum, scale and saturate the result that the final sample of a frame would produce.
    always_comb begin
        in_ext  = {{PH_W{In[NUM_INPUT_BITS-1]}}, In};
        sum     = acc_q + in_ext;
        sum_ext = {sum[ACC_W-1], sum};
`ifdef FIR_DECIM_ROUND_EN
        biased  = sum_ext + SUM_W'(BIAS);
`else
        biased  = sum_ext;
`endif
        shifted = biased >>> SHIFT;
        clip_hi = (shifted > OUT_MAX);
        clip_lo = (shifted < OUT_MIN);
        if (clip_hi) begin
            result = OUT_MAX[NUM_OUTPUT_BITS-1:0];
        end else if (clip_lo) begin
            result = OUT_MIN[NUM_OUTPUT_BITS-1:0];
        end else begin
            result = shifted[NUM_OUTPUT_BITS-1:0];
        end
    end

    // Next-state logic for the accumulator, the FIFO and the sticky flags; clr wins over everything.
    always_comb begin
        last_phase = (phase_q == PH_LAST);
        push       = in_valid && last_phase;
        full       = (count_q == CNT_FULL);
        pop        = out_valid && out_ready;
        // When the FIFO is full, a same-edge pop frees the slot that this push needs.
        do_push    = push && (!full || pop);

        acc_d      = acc_q;
        phase_d    = phase_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sat_d      = sat_q;

        if (clr) begin
            acc_d      = '0;
            phase_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            sat_d      = 1'b0;
        end else begin
            if (in_valid) begin
                if (last_phase) begin
                    acc_d   = '0;
                    phase_d = '0;
                end else begin
                    acc_d   = sum;
                    phase_d = phase_q + PH_W'(1);
                end
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            if (do_push) begin
                mem_d[wr_ptr_q] = result;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end

            if (do_push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && pop) begin
                count_d = count_q - CNT_W'(1);
            end

            if (push && full && !pop) begin
                overflow_d = 1'b1;
            end

            // A clipped result sets sat even when the FIFO then drops it.
            if (push && (clip_hi || clip_lo)) begin
                sat_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
        end
    end

    // Out reads zero while the FIFO is empty, so stale entries never show.
    assign out_valid = (count_q != '0);
    assign Out       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Self-checking bench for fir_decim_fifo (default parameters).
// A queue-based reference model tracks the expected FIFO contents and flags.
module tb_fir_decim_fifo;

    localparam int NI    = 16;
    localparam int NO    = 8;
    localparam int DECIM = 4;
    localparam int SHIFT = 2;
    localparam int DEPTH = 4;

    logic                 clk;
    logic                 rst_n;
    logic signed [NI-1:0] In;
    logic                 in_valid;
    logic                 clr;
    logic signed [NO-1:0] Out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overflow;
    logic                 sat;

    int n_checks = 0;
    int n_fail   = 0;

    longint m_acc;
    int     m_cnt;
    int     m_q[$];
    bit     m_ovf;
    bit     m_sat;

    fir_decim_fifo #(
        .NUM_INPUT_BITS (NI),
        .NUM_OUTPUT_BITS(NO),
        .DECIM          (DECIM),
        .SHIFT          (SHIFT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .In       (In),
        .in_valid (in_valid),
        .clr      (clr),
        .Out      (Out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow (overflow),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_q.delete();
        m_ovf = 0;
        m_sat = 0;
    endfunction

    function automatic logic signed [NO-1:0] exp_out();
        if (m_q.size() == 0) return '0;
        return NO'(m_q[0]);
    endfunction

    function automatic bit exp_valid();
        return m_q.size() != 0;
    endfunction

    // Apply one cycle of inputs, update the model for that edge, and return #1 after the edge.
    task automatic step(input int d, input bit v, input bit r, input bit c);
        longint s;
        int     res;
        bit     have;
        bit     pop;
        In        = NI'(d);
        in_valid  = v;
        out_ready = r;
        clr       = c;
        if (c) begin
            model_clear();
        end else begin
            have = 0;
            pop  = r && (m_q.size() != 0);
            if (v) begin
                m_acc += longint'(d);
                m_cnt++;
                if (m_cnt == DECIM) begin
                    s = m_acc;
`ifdef FIR_DECIM_ROUND_EN
                    if (SHIFT > 0) s = s + (longint'(1) << (SHIFT - 1));
`endif
                    s = s >>> SHIFT;
                    if (s > 127) begin
                        res = 127; m_sat = 1;
                    end else if (s < -128) begin
                        res = -128; m_sat = 1;
                    end else begin
                        res = int'(s);
                    end
                    have  = 1;
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (have) begin
                if (m_q.size() < DEPTH) m_q.push_back(res);
                else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; In = '0; in_valid = 0; clr = 0; out_ready = 0;
        model_clear();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_checks++; if (Out !== 8'sd0) begin n_fail++; $display("FAIL reset_out got=%0d exp=0", Out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got=%b exp=0", sat); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(100, 1, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        step(100, 1, 1, 0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        n_checks++; if (Out !== 8'sd100 || Out !== exp_out()) begin n_fail++; $display("FAIL basic_out got=%0d exp=100", Out); end
        step(0, 0, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop got=%b exp=0", out_valid); end
    endtask

    task automatic test_sat();
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(32767, 1, 0, 0);
        n_checks++; if (Out !== 8'sd127) begin n_fail++; $display("FAIL sat_hi_out got=%0d exp=127", Out); end
        n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_hi_flag got=%b exp=1", sat); end
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(-32768, 1, 0, 0);
        n_checks++; if (Out !== -8'sd128) begin n_fail++; $display("FAIL sat_lo_out got=%0d exp=-128", Out); end
        n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_sticky got=%b exp=1", sat); end
        step(0, 0, 1, 1);
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_clr got=%b exp=0", sat); end
    endtask

    task automatic test_rounding();
        logic signed [NO-1:0] exp_small;
`ifdef FIR_DECIM_ROUND_EN
        exp_small = 8'sd1;
`else
        exp_small = 8'sd0;
`endif
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
        n_checks++; if (out_valid !== 1'b1 || Out !== exp_small) begin n_fail++; $display("FAIL round_small got=%0d/%b exp=%0d/1", Out, out_valid, exp_small); end
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(-1, 1, 0, 0);
        n_checks++; if (Out !== -8'sd1) begin n_fail++; $display("FAIL round_neg got=%0d exp=-1", Out); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL round_nosat got=%b exp=0", sat); end
    endtask

    task automatic test_overflow();
        step(0, 0, 0, 1);
        for (int r = 1; r <= 5; r++)
            for (int i = 0; i < 4; i++) step(r * 10, 1, 0, 0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int r = 1; r <= 4; r++) begin
            n_checks++; if (out_valid !== 1'b1 || Out !== 8'(r * 10)) begin n_fail++; $display("FAIL ovf_drain got=%0d/%b exp=%0d/1", Out, out_valid, r * 10); end
            step(0, 0, 1, 0);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_back_to_back();
        int exp_seq[4] = '{20, 30, 40, 60};
        step(0, 0, 0, 1);
        for (int r = 1; r <= 4; r++)
            for (int i = 0; i < 4; i++) step(r * 10, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(60, 1, 0, 0);
        step(60, 1, 1, 0);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf got=%b exp=0", overflow); end
        n_checks++; if (Out !== 8'sd20 || out_valid !== 1'b1) begin n_fail++; $display("FAIL full_pp_head got=%0d exp=20", Out); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid !== 1'b1 || Out !== 8'(exp_seq[k])) begin n_fail++; $display("FAIL full_pp_drain got=%0d/%b exp=%0d/1", Out, out_valid, exp_seq[k]); end
            step(0, 0, 1, 0);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_count got=%b exp=0", out_valid); end
        // Count of one: a same-edge push and pop leaves the new result at the head.
        for (int i = 0; i < 4; i++) step(11, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(22, 1, 0, 0);
        step(22, 1, 1, 0);
        n_checks++; if (out_valid !== 1'b1 || Out !== 8'sd22) begin n_fail++; $display("FAIL one_pp_head got=%0d/%b exp=22/1", Out, out_valid); end
        step(0, 0, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL one_pp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_clr_priority();
        step(0, 0, 0, 1);
        step(70, 1, 0, 0); step(70, 1, 0, 0);
        step(70, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(8, 1, 0, 0);
        n_checks++; if (Out !== 8'sd8 || Out !== exp_out()) begin n_fail++; $display("FAIL clr_prio got=%0d exp=8", Out); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(127 * 4, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(32767, 1, 0, 0);
        step(100, 1, 0, 0); step(100, 1, 0, 0);
        rst_n = 1'b0; in_valid = 1'b0; model_clear();
        #1;
        n_checks++; if (out_valid !== 1'b0 || Out !== 8'sd0) begin n_fail++; $display("FAIL rstmid_async got=%0d/%b exp=0/0", Out, out_valid); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL rstmid_sat_async got=%b exp=0", sat); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) step(8, 1, 0, 0);
        n_checks++; if (out_valid !== 1'b1 || Out !== 8'sd8) begin n_fail++; $display("FAIL rstmid_out got=%0d/%b exp=8/1", Out, out_valid); end
        n_checks++; if (overflow !== 1'b0 || sat !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got=%b%b exp=00", overflow, sat); end
    endtask

    task automatic test_random();
        int  d;
        bit  v, r, c;
        step(0, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) d = int'(NI'($urandom)) - ((($urandom & 32'h8000) != 0) ? 0 : 0);
            else d = int'($urandom_range(0, 400)) - 200;
            if (d > 32767) d = d - 65536;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 79) == 0);
            step(d, v, r, c);
            n_checks++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, out_valid, exp_valid()); end
            n_checks++; if (Out !== exp_out()) begin n_fail++; $display("FAIL rand_out n=%0d got=%0d exp=%0d", n, Out, exp_out()); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
            n_checks++; if (sat !== m_sat) begin n_fail++; $display("FAIL rand_sat n=%0d got=%b exp=%b", n, sat, m_sat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_rounding();
        test_overflow();
        test_back_to_back();
        test_clr_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
